control_sequencer: RTL and testbench

//  Parametrised multicycle control FSM for the processor core. It sequences

---
 rtl/proc_pkg.sv | 54 +++++
 rtl/seq_step_counter.sv | 35 +++
 rtl/control_sequencer.sv | 147 ++++++++++++++
 tb/tb_control_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types for the multicycle control sequencer: state encoding,
// opcode/addressing-mode constants and a memory-wait state helper.
package proc_pkg;

    typedef enum logic [4:0] {
        FETCH = 5'd1,
        DEC_OP,
        DEC_ADDR,
        LOAD,
        IMMED,
        REGDIR,
        MEMDIR,
        PCREL,
        ASR,
        LSR,
        ASL,
        LSL,
        JMP,
        JZ,
        JNZ,
        POP,
        PUSH,
        ALU_WB,
        SHIFT_WB,
        PC_INC,
        HALT,
        IRQ
    } state_e;

    localparam logic [5:0] OP_ALU  = 6'b000000;
    localparam logic [5:0] OP_ALU2 = 6'b100001;
    localparam logic [5:0] OP_JMP  = 6'b001001;
    localparam logic [5:0] OP_JZ   = 6'b010000;
    localparam logic [5:0] OP_JNZ  = 6'b010001;
    localparam logic [5:0] OP_LOAD = 6'b100000;
    localparam logic [5:0] OP_POP  = 6'b100100;
    localparam logic [5:0] OP_PUSH = 6'b100110;
    localparam logic [5:0] OP_ASR  = 6'b111000;
    localparam logic [5:0] OP_LSR  = 6'b111001;
    localparam logic [5:0] OP_ASL  = 6'b111100;
    localparam logic [5:0] OP_LSL  = 6'b111101;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] FN_REGDIR = 3'b000;
    localparam logic [2:0] FN_MEMDIR = 3'b010;
    localparam logic [2:0] FN_PCREL  = 3'b110;

    // States whose final step waits for the memory handshake.
    function automatic logic is_mem_wait(state_e s);
        return (s == FETCH) || (s == MEMDIR) || (s == PCREL) ||
               (s == LOAD) || (s == POP) || (s == PUSH);
    endfunction

endpackage

// File: rtl/seq_step_counter.sv
// Per-state step counter: counts up to a limit and saturates there;
// done flags the last step of the current state.
module seq_step_counter #(
    parameter int STEP_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [STEP_W-1:0] limit_i,
    output logic [STEP_W-1:0] step_o,
    output logic              done_o
);

    logic [STEP_W-1:0] step_q, step_d;

    assign done_o = (step_q == limit_i);
    assign step_o = step_q;

    always_comb begin
        step_d = step_q;
        if (clr_i)
            step_d = '0;
        else if (en_i && !done_o)
            step_d = step_q + STEP_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            step_q <= '0;
        else
            step_q <= step_d;
    end

endmodule

// File: rtl/control_sequencer.sv
// Multicycle control FSM: fetch/decode/execute/writeback sequencing.
// Optional interrupt entry after branches/PC increment with CTRL_IRQ_EN.
module control_sequencer
    import proc_pkg::*;
#(
    parameter int STATE_W       = 6,
    parameter int STEP_W        = 3,
    parameter int FETCH_CYCLES  = 4,
    parameter int MEMDIR_CYCLES = 2,
    parameter int PCREL_CYCLES  = 5,
    parameter int IRQ_CYCLES    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [2:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    input  logic               irq,
    output logic [STATE_W-1:0] state,
    output logic [STEP_W-1:0]  step,
    output logic               state_entry,
    output logic               illegal_op,
    output logic               halted,
    output logic               irq_ack
);

    localparam logic [STEP_W-1:0] FETCH_LIM  = STEP_W'(FETCH_CYCLES - 1);
    localparam logic [STEP_W-1:0] MEMDIR_LIM = STEP_W'(MEMDIR_CYCLES - 1);
    localparam logic [STEP_W-1:0] PCREL_LIM  = STEP_W'(PCREL_CYCLES - 1);
    localparam logic [STEP_W-1:0] IRQ_LIM    = STEP_W'(IRQ_CYCLES - 1);

    state_e            state_q, state_d;
    logic              entry_q;
    logic              illegal_d;
    logic              trans;
    logic              done;
    logic              adv;
    logic [STEP_W-1:0] limit;
    state_e            ret_state;

    seq_step_counter #(.STEP_W(STEP_W)) u_step (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (trans),
        .en_i    (1'b1),
        .limit_i (limit),
        .step_o  (step),
        .done_o  (done)
    );

    always_comb begin
        limit = '0;
        unique case (state_q)
            FETCH:   limit = FETCH_LIM;
            MEMDIR:  limit = MEMDIR_LIM;
            PCREL:   limit = PCREL_LIM;
            IRQ:     limit = IRQ_LIM;
            default: limit = '0;
        endcase
    end

    // Single-cycle states have limit 0, so done is always set there.
    assign adv = done && (mem_ready || !is_mem_wait(state_q));

`ifdef CTRL_IRQ_EN
    assign ret_state = irq ? IRQ : FETCH;
`else
    assign ret_state = FETCH;
`endif

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            FETCH:
                if (adv) state_d = DEC_OP;
            DEC_OP: begin
                unique casez (op)
                    OP_ALU, OP_ALU2: state_d = ALU_WB;
                    OP_JMP:          state_d = JMP;
                    OP_JZ:           state_d = zero ? JZ : PC_INC;
                    OP_JNZ:          state_d = !zero ? JNZ : PC_INC;
                    OP_LOAD:         state_d = LOAD;
                    OP_POP:          state_d = POP;
                    OP_PUSH:         state_d = PUSH;
                    6'b110???:       state_d = DEC_ADDR;
                    OP_ASR:          state_d = ASR;
                    OP_LSR:          state_d = LSR;
                    OP_ASL:          state_d = ASL;
                    OP_LSL:          state_d = LSL;
                    OP_HALT:         state_d = HALT;
                    default: begin
                        state_d   = PC_INC;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            DEC_ADDR: begin
                unique case (funct)
                    FN_REGDIR: state_d = REGDIR;
                    FN_MEMDIR: state_d = MEMDIR;
                    FN_PCREL:  state_d = PCREL;
                    default:   state_d = IMMED;
                endcase
            end
            REGDIR, IMMED, MEMDIR, PCREL:
                if (adv) state_d = ALU_WB;
            ASR, LSR, ASL, LSL:
                state_d = SHIFT_WB;
            ALU_WB, SHIFT_WB, LOAD, POP, PUSH:
                if (adv) state_d = PC_INC;
            JMP, JZ, JNZ, PC_INC:
                state_d = ret_state;
            HALT:
                state_d = HALT;
            IRQ:
                if (adv) state_d = FETCH;
            default:
                state_d = FETCH;
        endcase
    end

    assign trans = (state_d != state_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            entry_q <= 1'b1;
        end else begin
            state_q <= state_d;
            entry_q <= trans;
        end
    end

    assign state       = STATE_W'(state_q);
    assign state_entry = entry_q;
    assign illegal_op  = illegal_d & ~reset;
    assign halted      = (state_q == HALT);

`ifdef CTRL_IRQ_EN
    assign irq_ack = (state_q == IRQ) && entry_q && !reset;
`else
    assign irq_ack = irq & 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer; IRQ checks follow CTRL_IRQ_EN.
module tb_control_sequencer;
    import proc_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [2:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       irq;
    logic [5:0] state;
    logic [2:0] step;
    logic       state_entry;
    logic       illegal_op;
    logic       halted;
    logic       irq_ack;

    int n_chk  = 0;
    int n_fail = 0;

    control_sequencer #(
        .STATE_W(6), .STEP_W(3), .FETCH_CYCLES(4),
        .MEMDIR_CYCLES(2), .PCREL_CYCLES(5), .IRQ_CYCLES(3)
    ) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .irq(irq), .state(state), .step(step),
        .state_entry(state_entry), .illegal_op(illegal_op),
        .halted(halted), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; op = 6'b101010; funct = '0; zero = 1'b0;
        mem_ready = 1'b1; irq = 1'b0;
        tick(); tick();
        n_chk++;
        if (state !== 6'(FETCH) || step !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state state/step=%0d/%0d expected %0d/0",
                     state, step, FETCH);
        end
        n_chk++;
        if ({state_entry, illegal_op, halted, irq_ack} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags entry/ill/halt/ack=%b expected 1000",
                     {state_entry, illegal_op, halted, irq_ack});
        end
        reset = 1'b0;
    endtask

    task automatic test_regdir;
        state_e es [10] = '{FETCH, FETCH, FETCH, FETCH, DEC_OP, DEC_ADDR,
                            REGDIR, ALU_WB, PC_INC, FETCH};
        int ss [10] = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0};
        bit ee [10] = '{1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        apply_reset();
        op = 6'b110000; funct = 3'b000; mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_chk++;
            if (state !== 6'(es[i]) || step !== 3'(ss[i]) ||
                state_entry !== ee[i]) begin
                n_fail++;
                $display("FAIL regdir[%0d] st/step/entry=%0d/%0d/%b expected %0d/%0d/%b",
                         i, state, step, state_entry, es[i], ss[i], ee[i]);
            end
            if (i < 9) tick();
        end
    endtask

    task automatic test_fetch_stall;
        int ss [8] = '{0, 1, 2, 3, 3, 3, 3, 0};
        apply_reset();
        op = 6'b000000;
        for (int i = 0; i < 8; i++) begin
            mem_ready = (i == 6);
            n_chk++;
            if (state !== 6'(i < 7 ? FETCH : DEC_OP) || step !== 3'(ss[i])) begin
                n_fail++;
                $display("FAIL fetch_stall[%0d] state/step=%0d/%0d expected %0d/%0d",
                         i, state, step, (i < 7 ? FETCH : DEC_OP), ss[i]);
            end
            if (i < 7) tick();
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_branch;
        state_e es [13] = '{FETCH, FETCH, FETCH, FETCH, DEC_OP, PC_INC, FETCH,
                            FETCH, FETCH, FETCH, DEC_OP, JZ, FETCH};
        apply_reset();
        op = 6'b010000; mem_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            zero = (i >= 6);
            n_chk++;
            if (state !== 6'(es[i])) begin
                n_fail++;
                $display("FAIL branch_jz[%0d] state=%0d expected %0d",
                         i, state, es[i]);
            end
            if (i < 12) tick();
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal;
        state_e es [7] = '{FETCH, FETCH, FETCH, FETCH, DEC_OP, PC_INC, FETCH};
        apply_reset();
        op = 6'b101010; mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            n_chk++;
            if (state !== 6'(es[i]) || illegal_op !== (i == 4)) begin
                n_fail++;
                $display("FAIL illegal[%0d] state/ill=%0d/%b expected %0d/%b",
                         i, state, illegal_op, es[i], (i == 4));
            end
            if (i < 6) tick();
        end
    endtask

    task automatic test_halt;
        apply_reset();
        op = 6'b111111; mem_ready = 1'b1;
        repeat (5) tick();
        op = 6'b000000;
        for (int i = 0; i < 20; i++) begin
            n_chk++;
            if (state !== 6'(HALT) || halted !== 1'b1) begin
                n_fail++;
                $display("FAIL halt[%0d] state/halted=%0d/%b expected %0d/1",
                         i, state, halted, HALT);
            end
            tick();
        end
        apply_reset();
        n_chk++;
        if (state !== 6'(FETCH) || halted !== 1'b0 || step !== 3'd0) begin
            n_fail++;
            $display("FAIL halt_exit state/halted/step=%0d/%b/%0d expected %0d/0/0",
                     state, halted, step, FETCH);
        end
    endtask

    task automatic test_load_stall;
        state_e es [10] = '{FETCH, FETCH, FETCH, FETCH, DEC_OP, LOAD, LOAD,
                            LOAD, PC_INC, FETCH};
        bit ee [10] = '{1, 0, 0, 0, 1, 1, 0, 0, 1, 1};
        apply_reset();
        op = 6'b100000;
        for (int i = 0; i < 10; i++) begin
            mem_ready = !(i == 5 || i == 6);
            n_chk++;
            if (state !== 6'(es[i]) || state_entry !== ee[i]) begin
                n_fail++;
                $display("FAIL load_stall[%0d] state/entry=%0d/%b expected %0d/%b",
                         i, state, state_entry, es[i], ee[i]);
            end
            if (i < 9) tick();
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_memdir_shift;
        state_e em [11] = '{FETCH, FETCH, FETCH, FETCH, DEC_OP, DEC_ADDR,
                            MEMDIR, MEMDIR, ALU_WB, PC_INC, FETCH};
        int sm [11] = '{0, 1, 2, 3, 0, 0, 0, 1, 0, 0, 0};
        state_e es [9] = '{FETCH, FETCH, FETCH, FETCH, DEC_OP, ASL,
                           SHIFT_WB, PC_INC, FETCH};
        apply_reset();
        op = 6'b110101; funct = 3'b010; mem_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            n_chk++;
            if (state !== 6'(em[i]) || step !== 3'(sm[i])) begin
                n_fail++;
                $display("FAIL memdir[%0d] state/step=%0d/%0d expected %0d/%0d",
                         i, state, step, em[i], sm[i]);
            end
            if (i < 10) tick();
        end
        apply_reset();
        op = 6'b111100;
        for (int i = 0; i < 9; i++) begin
            n_chk++;
            if (state !== 6'(es[i])) begin
                n_fail++;
                $display("FAIL shift_asl[%0d] state=%0d expected %0d",
                         i, state, es[i]);
            end
            if (i < 8) tick();
        end
    endtask

    task automatic test_pcrel_reset;
        state_e es [9] = '{FETCH, FETCH, FETCH, FETCH, DEC_OP, DEC_ADDR,
                           PCREL, PCREL, PCREL};
        int ss [9] = '{0, 1, 2, 3, 0, 0, 0, 1, 2};
        apply_reset();
        op = 6'b110000; funct = 3'b110; mem_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            n_chk++;
            if (state !== 6'(es[i]) || step !== 3'(ss[i])) begin
                n_fail++;
                $display("FAIL pcrel[%0d] state/step=%0d/%0d expected %0d/%0d",
                         i, state, step, es[i], ss[i]);
            end
            if (i < 8) tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_chk++;
        if (state !== 6'(FETCH) || step !== 3'd0 || state_entry !== 1'b1) begin
            n_fail++;
            $display("FAIL pcrel_reset state/step/entry=%0d/%0d/%b expected %0d/0/1",
                     state, step, state_entry, FETCH);
        end
    endtask

    task automatic test_irq;
`ifdef CTRL_IRQ_EN
        state_e es [10] = '{FETCH, FETCH, FETCH, FETCH, DEC_OP, JMP,
                            IRQ, IRQ, IRQ, FETCH};
        int ss [10] = '{0, 1, 2, 3, 0, 0, 0, 1, 2, 0};
        bit ack [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
`else
        state_e es [10] = '{FETCH, FETCH, FETCH, FETCH, DEC_OP, JMP,
                            FETCH, FETCH, FETCH, FETCH};
        int ss [10] = '{0, 1, 2, 3, 0, 0, 0, 1, 2, 3};
        bit ack [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        apply_reset();
        op = 6'b001001; mem_ready = 1'b1; irq = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_chk++;
            if (state !== 6'(es[i]) || step !== 3'(ss[i]) ||
                irq_ack !== ack[i]) begin
                n_fail++;
                $display("FAIL irq[%0d] st/step/ack=%0d/%0d/%b expected %0d/%0d/%b",
                         i, state, step, irq_ack, es[i], ss[i], ack[i]);
            end
            if (i < 9) tick();
        end
        irq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_regdir();
        test_fetch_stall();
        test_branch();
        test_illegal();
        test_halt();
        test_load_stall();
        test_memdir_shift();
        test_pcrel_reset();
        test_irq();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
